hypiu_core: RTL and testbench
=============================

HYPIU_CORE -- requirements
Module: hypiu_core

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, value loaded into pc_addr on reset.
REQ-002 One clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 instr  input  16  instruction word at pc_addr from external instruction memory, combinational.
REQ-006 pc_addr  output  16  current program counter.
REQ-007 rd_a, rd_b  input  16 each  register-file read data for addr_a/addr_b, combinational.
REQ-008 addr_a, addr_b, addr_w  output  3 each  register-file read/write addresses.
REQ-009 en_a, en_b  output  1 each  read enables; en_w  output  1  write enable, sampled by the register file on rising clk.
REQ-010 bus_w  output  16  write-back data, equal to the registered ALU result.
REQ-011 z_flag  output  1  registered zero flag.
REQ-012 halted  output  1  high once HALT has executed.

Function
REQ-013 Instruction fields: op=[15:12], rw=[11:9], ra=[8:6], rb=[5:3], imm8=[7:0].
REQ-014 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT(~A), 7 SHL(A<<B[3:0]), 8 SHR logical(A>>B[3:0]), 9 LDI(rw<=zero-extended imm8), A MOV(rw<=A), B JMP(pc<=A), C JZ, D JNZ, E CMP(A-B, flag only), F HALT.
REQ-015 Arithmetic is 16-bit modulo 2^16; carry/borrow discarded; shift counts 0..15.
REQ-016 FSM states EXEC, WB, HALT; EXEC->WB every instruction except HALT; WB->EXEC; EXEC->HALT on op F; HALT held until reset.
REQ-017 In EXEC: addr_a=ra, addr_b=rb, en_a=en_b=1; ALU result registered at the closing edge; instr must be valid throughout EXEC.
REQ-018 In WB: en_w=1 and addr_w=rw only for ops 1-A; bus_w = registered result; en_w=0 in EXEC and HALT.
REQ-019 z_flag updates at end of EXEC to (result==0) for ops 1-8 and E; held for all other ops.
REQ-020 PC updates at end of WB: JMP, JZ with z_flag=1, JNZ with z_flag=0 load rd_a latched in EXEC; otherwise pc+1, wrapping 16'hFFFF to 16'h0000.
REQ-021 JZ/JNZ test z_flag as it stands after the preceding instruction.
REQ-022 Writing register 0 has no special meaning; all eight registers are general.
REQ-023 NOP takes two cycles with no write and no flag change.
REQ-024 Throughput: exactly one instruction per two clocks until HALT.

Reset
REQ-025 Asserting reset at any time, including mid-instruction, forces state EXEC, pc_addr=RESET_PC, result register and bus_w=0, z_flag=0, halted=0, en_w=0 immediately.
REQ-026 After deassertion the first EXEC fetches from RESET_PC on the next rising edge.

Structure
REQ-027 A shared package holds ALU_BIT_NUM=4, the opcode enumeration and the FSM state encoding.
REQ-028 Sub-module hypiu_alu: combinational 16-bit ALU (a, b, oper -> result, zero); FSM, PC and registers stay in hypiu_core.
REQ-029 No tristate buses; all outputs are driven in every state.

Verification
REQ-030 Reset, then LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2 -> en_w pulses at cycles 2,4,6; bus_w=0x0008 with addr_w=3; z_flag=0.
REQ-031 SUB r4,r1,r1 with r1=5 -> bus_w=0x0000, z_flag=1; following JZ r5 with r5=0x0020 -> pc_addr=0x0020.
REQ-032 JNZ with z_flag=1 -> pc_addr increments by one; CMP r1,r2 (5,3) -> z_flag=0 and no en_w.
REQ-033 ADD 0xFFFF+0x0001 -> bus_w=0x0000, z_flag=1; SHL 0x0001 by 15 -> 0x8000; SHR 0x8000 by 15 -> 0x0001.
REQ-034 PC at 0xFFFF executing NOP -> pc_addr=0x0000; HALT -> halted=1, pc_addr frozen, en_w=0 for 10+ cycles.
REQ-035 Assert reset during WB of an ADD -> en_w drops immediately, pc_addr=RESET_PC, no write occurs.

Source files
------------

// File: rtl/hypiu_core_pkg.sv
`default_nettype none
// ============================================================================
// hypiu_core_pkg : opcodes, FSM states and decode helpers for the HYPIU core
// Rev 1.0
// ============================================================================
package hypiu_core_pkg;

  localparam int ALU_BIT_NUM = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NOT  = 4'h6,
    OP_SHL  = 4'h7,
    OP_SHR  = 4'h8,
    OP_LDI  = 4'h9,
    OP_MOV  = 4'hA,
    OP_JMP  = 4'hB,
    OP_JZ   = 4'hC,
    OP_JNZ  = 4'hD,
    OP_CMP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_EXEC = 2'd0,
    ST_WB   = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  function automatic logic op_writes(input opcode_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_SHL, OP_SHR, OP_LDI, OP_MOV: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic op_sets_flag(input opcode_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_SHL, OP_SHR, OP_CMP: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/hypiu_alu.sv
`default_nettype none
// ============================================================================
// hypiu_alu : combinational 16-bit ALU with zero detect
// Rev 1.0
// ============================================================================
module hypiu_alu
  import hypiu_core_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  opcode_e     oper,
  output logic [15:0] result,
  output logic        zero
);

  logic [ALU_BIT_NUM-1:0] shamt_w;
  assign shamt_w = b[ALU_BIT_NUM-1:0];

  // LDI arrives with the zero-extended immediate already muxed onto b
  always_comb begin
    result = '0;
    case (oper)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL:  result = a << shamt_w;
      OP_SHR:  result = a >> shamt_w;
      OP_LDI:  result = b;
      OP_MOV:  result = a;
      OP_CMP:  result = a - b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/hypiu_core.sv
`default_nettype none
// ============================================================================
// hypiu_core : two-cycle (EXEC/WB) 16-bit processor core with external RF/IMEM
// Rev 1.0
// ============================================================================
module hypiu_core
  import hypiu_core_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  output logic [15:0] pc_addr,
  input  logic [15:0] rd_a,
  input  logic [15:0] rd_b,
  output logic [2:0]  addr_a,
  output logic [2:0]  addr_b,
  output logic [2:0]  addr_w,
  output logic        en_a,
  output logic        en_b,
  output logic        en_w,
  output logic [15:0] bus_w,
  output logic        z_flag,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] result_q, result_d;
  logic [15:0] tgt_q, tgt_d;
  logic        z_q, z_d;
  opcode_e     op_q, op_d;
  logic [2:0]  rw_q, rw_d;

  opcode_e     op_w;
  logic [15:0] alu_b_w;
  logic [15:0] alu_res_w;
  logic        alu_zero_w;
  logic        take_w;

  assign op_w    = opcode_e'(instr[15:12]);
  assign alu_b_w = (op_w == OP_LDI) ? {8'h00, instr[7:0]} : rd_b;

  hypiu_alu u_alu (
    .a      (rd_a),
    .b      (alu_b_w),
    .oper   (op_w),
    .result (alu_res_w),
    .zero   (alu_zero_w)
  );

  // z_q here is still the flag left by the previous instruction
  assign take_w = (op_q == OP_JMP) ||
                  ((op_q == OP_JZ)  &&  z_q) ||
                  ((op_q == OP_JNZ) && !z_q);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    result_d = result_q;
    tgt_d    = tgt_q;
    z_d      = z_q;
    op_d     = op_q;
    rw_d     = rw_q;
    en_a     = 1'b0;
    en_b     = 1'b0;
    en_w     = 1'b0;
    addr_w   = 3'd0;
    case (state_q)
      ST_EXEC: begin
        en_a     = 1'b1;
        en_b     = 1'b1;
        result_d = alu_res_w;
        tgt_d    = rd_a;
        op_d     = op_w;
        rw_d     = instr[11:9];
        if (op_sets_flag(op_w)) z_d = alu_zero_w;
        state_d  = (op_w == OP_HALT) ? ST_HALT : ST_WB;
      end
      ST_WB: begin
        if (op_writes(op_q)) begin
          en_w   = 1'b1;
          addr_w = rw_q;
        end
        pc_d    = take_w ? tgt_q : pc_q + 16'd1;
        state_d = ST_EXEC;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_EXEC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_EXEC;
      pc_q     <= RESET_PC;
      result_q <= '0;
      tgt_q    <= '0;
      z_q      <= 1'b0;
      op_q     <= OP_NOP;
      rw_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      result_q <= result_d;
      tgt_q    <= tgt_d;
      z_q      <= z_d;
      op_q     <= op_d;
      rw_q     <= rw_d;
    end
  end

  assign pc_addr = pc_q;
  assign addr_a  = instr[8:6];
  assign addr_b  = instr[5:3];
  assign bus_w   = result_q;
  assign z_flag  = z_q;
  assign halted  = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_hypiu_core.sv
`default_nettype none
// ============================================================================
// tb_hypiu_core : directed and random checks of hypiu_core against an ISA model
// Rev 1.0
// ============================================================================
module tb_hypiu_core;

  localparam logic [15:0] RST_PC = 16'h0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr, pc_addr, rd_a, rd_b, bus_w;
  logic [2:0]  addr_a, addr_b, addr_w;
  logic        en_a, en_b, en_w, z_flag, halted;

  logic [15:0] imem [0:65535];
  logic [15:0] rf   [0:7] = '{default: 16'h0000};

  int n_cmp = 0;
  int n_fail = 0;

  // ISA-level reference state
  logic [15:0] regs_m [0:7];
  logic [15:0] pc_m;
  logic        z_m;
  logic        exp_wr;
  logic [2:0]  exp_wa;
  logic [15:0] exp_wd;

  logic        obs_en_ex, obs_en_wb;
  logic [2:0]  obs_wa;
  logic [15:0] obs_bus;

  hypiu_core #(.RESET_PC(RST_PC)) dut (
    .clk     (clk),
    .reset   (reset),
    .instr   (instr),
    .pc_addr (pc_addr),
    .rd_a    (rd_a),
    .rd_b    (rd_b),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .addr_w  (addr_w),
    .en_a    (en_a),
    .en_b    (en_b),
    .en_w    (en_w),
    .bus_w   (bus_w),
    .z_flag  (z_flag),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  assign instr = imem[pc_addr];
  assign rd_a  = en_a ? rf[addr_a] : 16'h0000;
  assign rd_b  = en_b ? rf[addr_b] : 16'h0000;

  always @(posedge clk) if (en_w) rf[addr_w] <= bus_w;

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rw,
                                      input logic [2:0] ra, input logic [2:0] rb);
    return {op, rw, ra, rb, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rw, input logic [7:0] imm);
    return {4'h9, rw, 1'b0, imm};
  endfunction

  task automatic model_reset();
    pc_m = RST_PC;
    z_m  = 1'b0;
  endtask

  task automatic model_exec(input logic [15:0] ins);
    logic [3:0]  op;
    logic [15:0] a, b, r;
    op = ins[15:12];
    a  = regs_m[ins[8:6]];
    b  = regs_m[ins[5:3]];
    r  = 16'h0000;
    exp_wr = 1'b0;
    exp_wa = ins[11:9];
    exp_wd = 16'h0000;
    case (op)
      4'h1: r = 16'((32'(a) + 32'(b)) % 65536);
      4'h2: r = 16'((32'(a) + 65536 - 32'(b)) % 65536);
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: r = 16'hFFFF - a;
      4'h7: r = 16'((32'(a) * (32'd1 << b[3:0])) % 65536);
      4'h8: r = a / (16'd1 << b[3:0]);
      4'h9: r = {8'h00, ins[7:0]};
      4'hA: r = a;
      4'hE: r = 16'((32'(a) + 65536 - 32'(b)) % 65536);
      default: r = 16'h0000;
    endcase
    if (op >= 4'h1 && op <= 4'hA) begin
      exp_wr = 1'b1;
      exp_wd = r;
      regs_m[ins[11:9]] = r;
    end
    if ((op >= 4'h1 && op <= 4'h8) || op == 4'hE) z_m = (r == 16'h0000);
    if (op == 4'hB || (op == 4'hC && z_m) || (op == 4'hD && !z_m)) pc_m = a;
    else if (op != 4'hF) pc_m = (pc_m == 16'hFFFF) ? 16'h0000 : pc_m + 16'd1;
  endtask

  // Called at a negedge during EXEC; returns at the negedge of the next EXEC
  task automatic issue(input logic [15:0] ins);
    imem[pc_m] = ins;
    obs_en_ex = en_w;
    model_exec(ins);
    @(negedge clk);
    obs_en_wb = en_w;
    obs_wa    = addr_w;
    obs_bus   = bus_w;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) regs_m[i] = 16'h0000;
    model_reset();
    @(negedge clk);
    n_cmp++; if (pc_addr !== RST_PC) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc_addr, RST_PC); end
    n_cmp++; if (en_w !== 1'b0) begin n_fail++; $display("FAIL reset_en_w got=%b exp=0", en_w); end
    n_cmp++; if (bus_w !== 16'h0000) begin n_fail++; $display("FAIL reset_bus_w got=%h exp=0000", bus_w); end
    n_cmp++; if (z_flag !== 1'b0) begin n_fail++; $display("FAIL reset_z got=%b exp=0", z_flag); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", halted); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    issue(ldi(3'd1, 8'h05));
    n_cmp++; if (obs_en_ex !== 1'b0 || obs_en_wb !== 1'b1) begin n_fail++; $display("FAIL ldi1_en_w got=%b%b exp=01", obs_en_ex, obs_en_wb); end
    n_cmp++; if (obs_bus !== 16'h0005) begin n_fail++; $display("FAIL ldi1_bus got=%h exp=0005", obs_bus); end
    issue(ldi(3'd2, 8'h03));
    n_cmp++; if (obs_en_ex !== 1'b0 || obs_en_wb !== 1'b1) begin n_fail++; $display("FAIL ldi2_en_w got=%b%b exp=01", obs_en_ex, obs_en_wb); end
    issue(enc(4'h1, 3'd3, 3'd1, 3'd2));
    n_cmp++; if (obs_en_ex !== 1'b0 || obs_en_wb !== 1'b1) begin n_fail++; $display("FAIL add_en_w got=%b%b exp=01", obs_en_ex, obs_en_wb); end
    n_cmp++; if (obs_bus !== 16'h0008 || obs_wa !== 3'd3) begin n_fail++; $display("FAIL add_bus got=%h@%0d exp=0008@3", obs_bus, obs_wa); end
    n_cmp++; if (z_flag !== 1'b0) begin n_fail++; $display("FAIL add_z got=%b exp=0", z_flag); end
    n_cmp++; if (pc_addr !== RST_PC + 16'd3) begin n_fail++; $display("FAIL add_pc got=%h exp=%h", pc_addr, RST_PC + 16'd3); end
  endtask

  task automatic test_flags_jumps();
    issue(ldi(3'd5, 8'h20));
    issue(enc(4'h2, 3'd4, 3'd1, 3'd1));
    n_cmp++; if (obs_bus !== 16'h0000 || z_flag !== 1'b1) begin n_fail++; $display("FAIL sub_zero got=%h z=%b exp=0000 z=1", obs_bus, z_flag); end
    issue(enc(4'hC, 3'd0, 3'd5, 3'd0));
    n_cmp++; if (pc_addr !== 16'h0020) begin n_fail++; $display("FAIL jz_taken got=%h exp=0020", pc_addr); end
    n_cmp++; if (obs_en_wb !== 1'b0) begin n_fail++; $display("FAIL jz_no_write got=%b exp=0", obs_en_wb); end
    issue(enc(4'hD, 3'd0, 3'd5, 3'd0));
    n_cmp++; if (pc_addr !== 16'h0021) begin n_fail++; $display("FAIL jnz_not_taken got=%h exp=0021", pc_addr); end
    issue(enc(4'hE, 3'd0, 3'd1, 3'd2));
    n_cmp++; if (z_flag !== 1'b0 || obs_en_wb !== 1'b0) begin n_fail++; $display("FAIL cmp got z=%b en_w=%b exp z=0 en_w=0", z_flag, obs_en_wb); end
  endtask

  task automatic test_edges();
    issue(ldi(3'd6, 8'h00));
    issue(enc(4'h6, 3'd6, 3'd6, 3'd0));
    n_cmp++; if (obs_bus !== 16'hFFFF) begin n_fail++; $display("FAIL not got=%h exp=ffff", obs_bus); end
    issue(ldi(3'd7, 8'h01));
    issue(enc(4'h1, 3'd0, 3'd6, 3'd7));
    n_cmp++; if (obs_bus !== 16'h0000 || obs_wa !== 3'd0 || z_flag !== 1'b1) begin n_fail++; $display("FAIL add_wrap got=%h@%0d z=%b exp=0000@0 z=1", obs_bus, obs_wa, z_flag); end
    issue(ldi(3'd2, 8'h0F));
    issue(enc(4'h7, 3'd3, 3'd7, 3'd2));
    n_cmp++; if (obs_bus !== 16'h8000) begin n_fail++; $display("FAIL shl15 got=%h exp=8000", obs_bus); end
    issue(enc(4'h8, 3'd4, 3'd3, 3'd2));
    n_cmp++; if (obs_bus !== 16'h0001 || z_flag !== 1'b0) begin n_fail++; $display("FAIL shr15 got=%h z=%b exp=0001 z=0", obs_bus, z_flag); end
  endtask

  task automatic test_pc_wrap();
    issue(ldi(3'd1, 8'hFF));
    issue(ldi(3'd2, 8'h08));
    issue(enc(4'h7, 3'd1, 3'd1, 3'd2));
    issue(ldi(3'd3, 8'hFF));
    issue(enc(4'h4, 3'd1, 3'd1, 3'd3));
    issue(enc(4'hB, 3'd0, 3'd1, 3'd0));
    n_cmp++; if (pc_addr !== 16'hFFFF) begin n_fail++; $display("FAIL jmp_ffff got=%h exp=ffff", pc_addr); end
    issue(16'h0000);
    n_cmp++; if (pc_addr !== 16'h0000 || obs_en_wb !== 1'b0) begin n_fail++; $display("FAIL nop_wrap got=%h en_w=%b exp=0000 en_w=0", pc_addr, obs_en_wb); end
  endtask

  task automatic test_reset_mid_wb();
    logic [15:0] ins;
    issue(enc(4'h2, 3'd4, 3'd1, 3'd1));
    ins = enc(4'h1, 3'd3, 3'd1, 3'd2);
    imem[pc_m] = ins;
    @(negedge clk);
    n_cmp++; if (en_w !== 1'b1) begin n_fail++; $display("FAIL mid_wb_entry got=%b exp=1", en_w); end
    reset = 1'b1;
    #1;
    n_cmp++; if (en_w !== 1'b0 || pc_addr !== RST_PC) begin n_fail++; $display("FAIL mid_wb_reset got en_w=%b pc=%h exp en_w=0 pc=%h", en_w, pc_addr, RST_PC); end
    n_cmp++; if (bus_w !== 16'h0000 || z_flag !== 1'b0) begin n_fail++; $display("FAIL mid_wb_clear got bus=%h z=%b exp 0000 0", bus_w, z_flag); end
    @(negedge clk);
    n_cmp++; if (rf[3] !== regs_m[3]) begin n_fail++; $display("FAIL mid_wb_no_write got=%h exp=%h", rf[3], regs_m[3]); end
    reset = 1'b0;
    model_reset();
    issue(ldi(3'd1, 8'h5A));
    n_cmp++; if (pc_addr !== RST_PC + 16'd1 || obs_bus !== 16'h005A) begin n_fail++; $display("FAIL post_reset got pc=%h bus=%h exp pc=%h bus=005a", pc_addr, obs_bus, RST_PC + 16'd1); end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    for (int k = 0; k < 400; k++) begin
      ins = {4'($urandom_range(0, 14)), 12'($urandom)};
      issue(ins);
      n_cmp++; if (obs_en_ex !== 1'b0 || obs_en_wb !== exp_wr) begin n_fail++; $display("FAIL rnd_en_w[%0d] ins=%h got=%b%b exp=0%b", k, ins, obs_en_ex, obs_en_wb, exp_wr); end
      if (exp_wr) begin
        n_cmp++; if (obs_wa !== exp_wa || obs_bus !== exp_wd) begin n_fail++; $display("FAIL rnd_wb[%0d] ins=%h got=%h@%0d exp=%h@%0d", k, ins, obs_bus, obs_wa, exp_wd, exp_wa); end
      end
      n_cmp++; if (pc_addr !== pc_m || z_flag !== z_m) begin n_fail++; $display("FAIL rnd_state[%0d] ins=%h got pc=%h z=%b exp pc=%h z=%b", k, ins, pc_addr, z_flag, pc_m, z_m); end
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (rf[i] !== regs_m[i]) begin n_fail++; $display("FAIL rnd_rf[%0d] got=%h exp=%h", i, rf[i], regs_m[i]); end
    end
  endtask

  task automatic test_halt();
    logic [15:0] pc_hold;
    pc_hold = pc_m;
    issue(16'hF000);
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag got=%b exp=1", halted); end
    for (int c = 0; c < 12; c++) begin
      n_cmp++; if (en_w !== 1'b0 || pc_addr !== pc_hold || halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold[%0d] got en_w=%b pc=%h h=%b exp 0 %h 1", c, en_w, pc_addr, halted, pc_hold); end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    n_cmp++; if (halted !== 1'b0 || pc_addr !== RST_PC) begin n_fail++; $display("FAIL halt_reset got h=%b pc=%h exp 0 %h", halted, pc_addr, RST_PC); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags_jumps();
    test_edges();
    test_pc_wrap();
    test_reset_mid_wb();
    test_random();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
